// File: rtl/rare_event_monitor.sv
// rare_event_monitor: observes a single subcircuit output bit while armed,
// tracking the current run of ones, the number of transitions and a MISR
// signature of the sampled stream. A sticky alarm fires when the run of
// ones reaches the threshold latched at arm time (threshold 0 disables it).
module rare_event_monitor #(
    parameter int              CNT_W = 8,
    parameter int              SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = 16'h1021
) (
    input  logic             I1470_clk,
    input  logic             I1477_rst,
    input  logic             in_bit,
    input  logic             sample_en,
    input  logic             arm,
    input  logic             clear,
    input  logic [CNT_W-1:0] threshold,
    output logic [1:0]       state,
    output logic             alarm,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [SIG_W-1:0] signature
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_TRIG  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic               alarm_q, alarm_d;
    logic [CNT_W-1:0]   run_q, run_d;
    logic [CNT_W-1:0]   tog_q, tog_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic               prev_q, prev_d;
    logic [CNT_W-1:0]   thr_q, thr_d;

    // Candidate values for one accepted sample, used only in ARMED
    logic [CNT_W-1:0]   run_new;
    logic [CNT_W-1:0]   tog_new;
    logic [SIG_W-1:0]   sig_new;

    // Per-sample datapath: saturating counters and MISR shift
    always_comb begin
        run_new = '0;
        if (in_bit) begin
            run_new = (run_q == {CNT_W{1'b1}}) ? run_q : run_q + 1'b1;
        end
        tog_new = tog_q;
        if ((in_bit != prev_q) && (tog_q != {CNT_W{1'b1}})) begin
            tog_new = tog_q + 1'b1;
        end
        sig_new = ({sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0))
                  ^ {{(SIG_W-1){1'b0}}, in_bit};
    end

    // Next-state logic: clear beats arm, arm beats sampling
    always_comb begin
        state_d = state_q;
        alarm_d = alarm_q;
        run_d   = run_q;
        tog_d   = tog_q;
        sig_d   = sig_q;
        prev_d  = prev_q;
        thr_d   = thr_q;

        if (clear) begin
            state_d = ST_IDLE;
            alarm_d = 1'b0;
            run_d   = '0;
            tog_d   = '0;
            sig_d   = '0;
            prev_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d = ST_ARMED;
                        thr_d   = threshold;
                        run_d   = '0;
                        tog_d   = '0;
                        sig_d   = '0;
                        prev_d  = 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (arm) begin
                        // Re-arm discards any sample offered on this edge
                        thr_d   = threshold;
                        run_d   = '0;
                        tog_d   = '0;
                        sig_d   = '0;
                        prev_d  = 1'b0;
                    end else if (sample_en) begin
                        run_d  = run_new;
                        tog_d  = tog_new;
                        sig_d  = sig_new;
                        prev_d = in_bit;
                        if ((thr_q != '0) && (run_new >= thr_q)) begin
                            state_d = ST_TRIG;
                            alarm_d = 1'b1;
                        end
                    end
                end
                ST_TRIG: begin
                    // Frozen until clear or reset
                end
                default: begin
                    // Unused encoding recovers to IDLE with registers held
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            state_q <= ST_IDLE;
            alarm_q <= 1'b0;
            run_q   <= '0;
            tog_q   <= '0;
            sig_q   <= '0;
            prev_q  <= 1'b0;
            thr_q   <= '0;
        end else begin
            state_q <= state_d;
            alarm_q <= alarm_d;
            run_q   <= run_d;
            tog_q   <= tog_d;
            sig_q   <= sig_d;
            prev_q  <= prev_d;
            thr_q   <= thr_d;
        end
    end

    assign state      = state_q;
    assign alarm      = alarm_q;
    assign run_len    = run_q;
    assign toggle_cnt = tog_q;
    assign signature  = sig_q;

endmodule
